// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared types and constants for the keypad command conditioner
package connect4_pkg;

    localparam logic [3:0] KEY_NONE = 4'h0;
    localparam int COL_W = 3;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } key_state_t;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic             pop;
    } cmd_t;

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - 2-flop synchroniser plus debounce counter with stable value and rise pulse
module debounce_sync
    import connect4_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] stable_nxt,
    output logic [WIDTH-1:0] rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;

    // Exposed so downstream logic can react on the same edge the stable value updates.
    assign stable_nxt = (cnt == CNT_MAX) ? cand : stable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
            rise   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            stable <= stable_nxt;
            rise   <= stable_nxt & ~stable;
        end
    end

endmodule

// File: rtl/keypad_cmd_conditioner.sv
// rtl/keypad_cmd_conditioner.sv - keypad/button conditioner issuing column commands; CMD_SKID_EN adds a one-entry skid
module keypad_cmd_conditioner
    import connect4_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int NUM_COLS        = 7
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [3:0]       key_code,
    input  logic             pop_in,
    input  logic             btn_game,
    input  logic             btn_score,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [COL_W-1:0] cmd_col,
    output logic             cmd_pop,
    output logic             cmd_overrun,
    output logic             reset_game_pulse,
    output logic             reset_score_pulse
);

    logic [4:0] kp_stable, kp_nxt, kp_rise;
    logic       bg_stable, bg_nxt;
    logic       bs_stable, bs_nxt;
    logic       unused_dbg;

    debounce_sync #(.WIDTH(5), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .clk(clk), .rst(clr), .din({pop_in, key_code}),
        .stable(kp_stable), .stable_nxt(kp_nxt), .rise(kp_rise)
    );

    debounce_sync #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_game_db (
        .clk(clk), .rst(clr), .din(btn_game),
        .stable(bg_stable), .stable_nxt(bg_nxt), .rise(reset_game_pulse)
    );

    debounce_sync #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_score_db (
        .clk(clk), .rst(clr), .din(btn_score),
        .stable(bs_stable), .stable_nxt(bs_nxt), .rise(reset_score_pulse)
    );

    assign unused_dbg = ^{kp_stable, kp_rise, bg_stable, bg_nxt, bs_stable, bs_nxt};

    logic [3:0] key_nxt;
    logic       pop_nxt;
    assign key_nxt = kp_nxt[3:0];
    assign pop_nxt = kp_nxt[4];

    key_state_t state, state_nxt;
    logic       gen;
    cmd_t       gen_cmd;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    // A command is only issued on the IDLE->HELD edge; key changes while held are ignored.
    always_comb begin
        state_nxt = state;
        gen       = 1'b0;
        gen_cmd   = '0;
        case (state)
            IDLE: begin
                if (key_nxt != KEY_NONE) begin
                    state_nxt = HELD;
                    if (int'(key_nxt) <= NUM_COLS) begin
                        gen         = 1'b1;
                        gen_cmd.col = COL_W'(key_nxt - 4'd1);
                        gen_cmd.pop = pop_nxt;
                    end
                end
            end
            HELD: begin
                if (key_nxt == KEY_NONE) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    cmd_t out_cmd;
    logic xfer;
    assign xfer    = cmd_valid && cmd_ready;
    assign cmd_col = out_cmd.col;
    assign cmd_pop = out_cmd.pop;

`ifdef CMD_SKID_EN
    cmd_t skid_cmd;
    logic skid_valid;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cmd_valid   <= 1'b0;
            out_cmd     <= '0;
            cmd_overrun <= 1'b0;
            skid_cmd    <= '0;
            skid_valid  <= 1'b0;
        end else begin
            cmd_overrun <= 1'b0;
            if (reset_game_pulse) begin
                cmd_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (xfer) begin
                if (skid_valid) begin
                    out_cmd    <= skid_cmd;
                    cmd_valid  <= 1'b1;
                    skid_valid <= gen;
                    if (gen) skid_cmd <= gen_cmd;
                end else begin
                    cmd_valid <= gen;
                    if (gen) out_cmd <= gen_cmd;
                end
            end else if (!cmd_valid) begin
                if (gen) begin
                    out_cmd   <= gen_cmd;
                    cmd_valid <= 1'b1;
                end
            end else if (gen) begin
                if (!skid_valid) begin
                    skid_cmd   <= gen_cmd;
                    skid_valid <= 1'b1;
                end else begin
                    cmd_overrun <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cmd_valid   <= 1'b0;
            out_cmd     <= '0;
            cmd_overrun <= 1'b0;
        end else begin
            cmd_overrun <= 1'b0;
            if (reset_game_pulse) begin
                cmd_valid <= 1'b0;
            end else if (gen) begin
                if (!cmd_valid || xfer) begin
                    out_cmd   <= gen_cmd;
                    cmd_valid <= 1'b1;
                end else begin
                    cmd_overrun <= 1'b1;
                end
            end else if (xfer) begin
                cmd_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_keypad_cmd_conditioner.sv
// tb/tb_keypad_cmd_conditioner.sv - scoreboard bench for keypad_cmd_conditioner with DEBOUNCE_CYCLES=4
module tb_keypad_cmd_conditioner;

    localparam int DB = 4;
`ifdef CMD_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] col;
        logic       pop;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] key_code = 4'h0;
    logic       pop_in = 1'b0;
    logic       btn_game = 1'b0;
    logic       btn_score = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [2:0] cmd_col;
    logic       cmd_pop;
    logic       cmd_overrun;
    logic       reset_game_pulse;
    logic       reset_score_pulse;

    keypad_cmd_conditioner #(.DEBOUNCE_CYCLES(DB), .NUM_COLS(7)) dut (
        .clk(clk), .clr(clr), .key_code(key_code), .pop_in(pop_in),
        .btn_game(btn_game), .btn_score(btn_score),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_col(cmd_col), .cmd_pop(cmd_pop), .cmd_overrun(cmd_overrun),
        .reset_game_pulse(reset_game_pulse), .reset_score_pulse(reset_score_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_pass = 0;
    int   n_xfer = 0;
    int   n_overrun = 0;
    int   n_rg = 0;
    int   n_rs = 0;
    int   n_vcyc = 0;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic [2:0] pc = 3'd0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!clr) begin
                if (pv && !pr && cmd_valid) chk("hold_col", cmd_col, pc);
                if (cmd_valid) n_vcyc++;
                if (cmd_valid && cmd_ready) begin
                    n_xfer++;
                    chk("sb_expected_cmd", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("sb_col", cmd_col, e.col);
                        chk("sb_pop", cmd_pop, e.pop);
                    end
                end
                if (cmd_overrun) n_overrun++;
                if (reset_game_pulse) n_rg++;
                if (reset_score_pulse) n_rs++;
            end
            pv = cmd_valid;
            pr = cmd_ready;
            pc = cmd_col;
        end
    endtask

    initial begin
        int   t0, lat, x0, o0, g0, s0, v0;
        bit   found;
        fork
            monitor();
        join_none

        // reset state
        tick(3);
        @(negedge clk);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_col", cmd_col, 0);
        chk("rst_pop", cmd_pop, 0);
        chk("rst_overrun", cmd_overrun, 0);
        chk("rst_game", reset_game_pulse, 0);
        chk("rst_score", reset_score_pulse, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        tick(10);

        // T1: clean press of key 3, latency and single command
        x0 = n_xfer; v0 = n_vcyc;
        exp_q.push_back('{col: 3'd2, pop: 1'b0});
        key_code = 4'd3;
        t0 = cyc; lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cmd_valid) begin
                lat = cyc - t0;
                break;
            end
        end
        chk("t1_latency", lat, DB + 3);
        tick(20);
        key_code = 4'd0;
        tick(12);
        chk("t1_one_xfer", n_xfer - x0, 1);
        chk("t1_one_valid_cycle", n_vcyc - v0, 1);

        // T2: bouncing key 5, then steady
        x0 = n_xfer;
        for (int i = 0; i < 15; i++) begin
            key_code = (i % 2 == 0) ? 4'd5 : 4'd0;
            tick(2);
        end
        chk("t2_no_cmd_in_bounce", n_xfer - x0, 0);
        exp_q.push_back('{col: 3'd4, pop: 1'b0});
        key_code = 4'd5;
        tick(15);
        chk("t2_one_cmd", n_xfer - x0, 1);
        key_code = 4'd0;
        tick(12);

        // T3: output occupied, second command overrun (or skid)
        cmd_ready = 1'b0;
        x0 = n_xfer; o0 = n_overrun;
        exp_q.push_back('{col: 3'd0, pop: 1'b0});
        key_code = 4'd1;
        tick(12);
        chk("t3_valid", cmd_valid, 1);
        chk("t3_col0", cmd_col, 0);
        key_code = 4'd0;
        tick(12);
        if (SKID) exp_q.push_back('{col: 3'd1, pop: 1'b0});
        key_code = 4'd2;
        tick(12);
        chk("t3_col_held", cmd_col, 0);
        chk("t3_overrun", n_overrun - o0, SKID ? 0 : 1);
        key_code = 4'd0;
        tick(12);
        cmd_ready = 1'b1;
        tick(5);
        chk("t3_xfers", n_xfer - x0, SKID ? 2 : 1);

        // T4: key 6 with pop, slide to 9, release and press 9 again
        x0 = n_xfer;
        exp_q.push_back('{col: 3'd5, pop: 1'b1});
        pop_in = 1'b1;
        key_code = 4'd6;
        tick(12);
        key_code = 4'd9;
        tick(12);
        key_code = 4'd0;
        tick(12);
        key_code = 4'd9;
        tick(12);
        key_code = 4'd0;
        pop_in = 1'b0;
        tick(12);
        chk("t4_one_cmd", n_xfer - x0, 1);

        // boundaries: key 8 ignored, key 7 maps to last column
        x0 = n_xfer;
        key_code = 4'd8;
        tick(12);
        key_code = 4'd0;
        tick(12);
        chk("t4_key8_none", n_xfer - x0, 0);
        exp_q.push_back('{col: 3'd6, pop: 1'b0});
        key_code = 4'd7;
        tick(12);
        key_code = 4'd0;
        tick(12);
        chk("t4_key7_cmd", n_xfer - x0, 1);

        // T5: reset-game clears a pending command
        cmd_ready = 1'b0;
        x0 = n_xfer; o0 = n_overrun; g0 = n_rg; s0 = n_rs;
        key_code = 4'd3;
        tick(12);
        chk("t5_pending", cmd_valid, 1);
        key_code = 4'd0;
        tick(12);
        btn_game = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (reset_game_pulse) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_pulse_seen", found, 1);
        @(negedge clk);
        chk("t5_valid_cleared", cmd_valid, 0);
        tick(10);
        btn_game = 1'b0;
        tick(12);
        chk("t5_one_game_pulse", n_rg - g0, 1);
        chk("t5_no_overrun", n_overrun - o0, 0);
        btn_score = 1'b1;
        tick(14);
        btn_score = 1'b0;
        tick(12);
        chk("t5_one_score_pulse", n_rs - s0, 1);
        chk("t5_game_unchanged", n_rg - g0, 1);
        cmd_ready = 1'b1;
        tick(5);
        chk("t5_cleared_no_xfer", n_xfer - x0, 0);

        // T6: clr while key 4 held, then re-debounce
        x0 = n_xfer;
        exp_q.push_back('{col: 3'd3, pop: 1'b0});
        key_code = 4'd4;
        tick(12);
        chk("t6_first_cmd", n_xfer - x0, 1);
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_outputs_in_clr",
                {cmd_valid, cmd_col, cmd_pop, cmd_overrun, reset_game_pulse, reset_score_pulse}, 0);
        end
        @(posedge clk); #1;
        exp_q.push_back('{col: 3'd3, pop: 1'b0});
        clr = 1'b0;
        tick(15);
        chk("t6_redebounce_cmd", n_xfer - x0, 2);
        key_code = 4'd0;
        tick(12);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_cmd_conditioner.md
Name: keypad_cmd_conditioner

Overview:
Sits between the PMOD keypad decoder and the connect4 game logic.
- Synchronises and debounces the decoder's 4-bit key code, pop level and the two board push buttons.
- Turns each debounced keypad press into exactly one column command, offered on a valid/ready handshake.
- Produces single-cycle reset-game and reset-score pulses.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, clk cycles an input must stay unchanged before it is accepted (10 ms at 100 MHz); minimum 2
NUM_COLS, 7, playable columns; keys 1..NUM_COLS map to columns 0..NUM_COLS-1

Ports:
clk  in  1  system clock, 100 MHz
clr  in  1  asynchronous, active-high reset
key_code  in  4  decoder key code; 4'h0 = no key held
pop_in  in  1  decoder pop-mode level
btn_game  in  1  raw reset-game button (btnR)
btn_score  in  1  raw reset-score button (btnL)
cmd_valid  out  1  command available
cmd_ready  in  1  game logic accepts command
cmd_col  out  3  target column, 0..NUM_COLS-1
cmd_pop  out  1  1 = pop from bottom, 0 = drop
cmd_overrun  out  1  one-cycle pulse: command discarded
reset_game_pulse  out  1  one-cycle pulse on debounced btn_game press
reset_score_pulse  out  1  one-cycle pulse on debounced btn_score press

Behaviour:
- Reset values: all outputs 0; key FSM in IDLE; debounce counters 0; stable values 0.
- Synchronisation: every input (key_code, pop_in, btn_game, btn_score) passes through a 2-flop synchroniser.
- Debounce, per channel:
  - Synced value != candidate: load candidate, clear counter.
  - Otherwise: count up, saturating.
  - Counter == DEBOUNCE_CYCLES-1: stable <= candidate.
  - Latency from a clean input edge to the stable change is DEBOUNCE_CYCLES+3 cycles.
- Buttons: a rising edge of the stable button value produces a one-cycle pulse. Holding a button produces no further pulses.
- Key FSM, states IDLE and HELD:
  - IDLE -> HELD when stable key goes nonzero. On that transition, if the key is in 1..NUM_COLS, generate a command: col = key-1, pop = stable pop_in at the same cycle.
  - Keys 0x8..0xF: enter HELD with no command.
  - HELD -> IDLE only when stable key == 0.
  - A direct change from one nonzero key to another nonzero key gives no new command; the key must be released first.
- Handshake:
  - cmd_valid rises the cycle after generation.
  - cmd_col and cmd_pop are held stable while cmd_valid=1.
  - Transfer happens when cmd_valid && cmd_ready; cmd_valid drops the next cycle unless a queued command exists.
  - A new command arriving the same cycle as a transfer is accepted (no overrun).
- Overrun: a new command while the output is occupied (and no transfer that cycle) is discarded, and cmd_overrun pulses for one cycle.
- Reset-game priority:
  - A reset_game_pulse cycle clears any pending or queued command: cmd_valid -> 0 next cycle, no overrun pulse.
  - A command generated in the same cycle is dropped.
  - The key FSM is unaffected.
- Reset mid-press: clr asserted while a key is held returns the FSM to IDLE. After clr releases, the still-held key debounces anew and produces one command.

Optional Feature:
CMD_SKID_EN
- Defined: adds a one-entry skid register. A command arriving while the output is occupied is queued. It moves to the output the cycle after the current one transfers, with cmd_valid staying continuously high. Overrun fires only when both output and skid are full. reset_game_pulse clears both.
- Undefined: no skid register; overrun behaves as described under Behaviour.

Decomposition:
- Package connect4_pkg:
  - KEY_NONE = 4'h0
  - COL_W = 3
  - key FSM state typedef (IDLE, HELD)
  - cmd struct {col, pop}
  - DEBOUNCE_CYCLES default constant
- Sub-module debounce_sync, parameterised on WIDTH and DEBOUNCE_CYCLES:
  - Contains the 2-flop synchroniser, counter, stable output and rise pulse.
  - Instantiated once with WIDTH=5 (key_code plus pop_in) and twice with WIDTH=1 (buttons).

Test Plan (DEBOUNCE_CYCLES=4):
- key_code 0->3 held 20 cycles, pop_in=0, cmd_ready=1 -> exactly one cmd_valid cycle, cmd_col=2, cmd_pop=0, at cycle 7 after the edge.
- key_code toggling 0/5 every 2 cycles for 30 cycles, then steady 5 -> no command during bounce; one command col=4 afterward.
- key 1 pressed, cmd_ready=0; release; press key 2 -> cmd_col stays 0; cmd_overrun pulses once; with CMD_SKID_EN, no overrun and col=1 follows after the ready handshake.
- key 6 pressed with pop_in=1, then key 6->9 without release -> one command col=5, pop=1; key 9 yields nothing; key 9->0->9 yields nothing.
- cmd pending (cmd_ready=0), btn_game pressed 10 cycles -> one reset_game_pulse; cmd_valid falls next cycle; no overrun.
- Key 4 held while clr pulsed for 3 cycles -> all outputs 0 during clr; one command col=3 after re-debounce.
